// File: rtl/eth_rx_ring.sv
// Receive frame ring: filters incoming AXIS frames by destination MAC, stores accepted frames
// in an NBUF-slot byte ring with a per-slot length table, and exposes host pointers and an IRQ.
module eth_rx_ring #(
  parameter int NBUF      = 8,
  parameter int BUF_BYTES = 2048,
  parameter int HOST_W    = 64,
  parameter int MIN_LEN   = 14
) (
  input  logic                                        clk_int,
  input  logic                                        rst_int,
  input  logic [7:0]                                  rx_axis_tdata,
  input  logic                                        rx_axis_tvalid,
  input  logic                                        rx_axis_tlast,
  input  logic                                        rx_axis_tuser,
  input  logic [47:0]                                 mac_address,
  input  logic                                        promiscuous,
  input  logic                                        irq_en,
  input  logic                                        rd_en,
  input  logic [$clog2(NBUF*BUF_BYTES*8/HOST_W)-1:0]  rd_addr,
  output logic [HOST_W-1:0]                           rd_data,
  input  logic [$clog2(NBUF)-1:0]                     len_idx,
  output logic [15:0]                                 len_data,
  input  logic                                        firstbuf_we,
  input  logic [$clog2(NBUF):0]                       firstbuf_wdata,
  output logic [$clog2(NBUF):0]                       firstbuf,
  output logic [$clog2(NBUF):0]                       nextbuf,
  output logic                                        avail,
  output logic                                        full,
  output logic [15:0]                                 drop_cnt,
  output logic                                        eth_irq
);

  localparam int IDX_W  = $clog2(NBUF);
  localparam int PTR_W  = IDX_W + 1;
  localparam int LANE_W = $clog2(HOST_W / 8);
  localparam int OFF_W  = $clog2(BUF_BYTES);
  localparam int CNT_W  = OFF_W + 1;
  localparam int DEPTH  = NBUF * BUF_BYTES * 8 / HOST_W;

  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(BUF_BYTES);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] CNT_DST  = CNT_W'(5);
  localparam logic [PTR_W-1:0] PTR_NBUF = PTR_W'(NBUF);

  typedef enum logic [1:0] {IDLE, RECV, DROP, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d, new_len;
  logic [OFF_W-1:0]   wr_off;
  logic [IDX_W-1:0]   wr_slot;
  logic               wr_en, drop_inc, len_ld, start_full, filt_ok;
  logic [39:0]        dest_q;
  logic [47:0]        dest_now;
  logic [15:0]        frame_len_q;
  logic [PTR_W-1:0]   fill, fill_post;
  logic [15:0]        len_table [NBUF];
  logic [HOST_W-1:0]  mem [DEPTH];

  assign fill      = nextbuf - firstbuf;
  assign fill_post = nextbuf + PTR_W'(1) - firstbuf;
  assign avail     = (nextbuf != firstbuf);
  assign full      = (fill == PTR_NBUF);
  assign len_data  = len_table[len_idx];
  assign new_len   = wr_ptr_q + CNT_W'(1);
  assign dest_now  = {dest_q, rx_axis_tdata};

  // Only byte 5 decides the filter; a frame still in RECV past byte 5 has already passed.
  assign filt_ok = (wr_ptr_q != CNT_DST) || promiscuous || (dest_now == mac_address)
                   || (&dest_now) || (dest_now[47:24] == 24'h01005E);

  always_ff @(posedge clk_int) begin
    if (rst_int) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_en      = 1'b0;
    wr_off     = wr_ptr_q[OFF_W-1:0];
    drop_inc   = 1'b0;
    len_ld     = 1'b0;
    wr_slot    = nextbuf[IDX_W-1:0];
    start_full = full;
    // A byte arriving during COMMIT belongs to the slot after the one being committed.
    if (state_q == COMMIT) begin
      wr_slot    = nextbuf[IDX_W-1:0] + IDX_W'(1);
      start_full = (fill_post == PTR_NBUF);
    end
    case (state_q)
      IDLE, COMMIT: begin
        state_d = IDLE;
        if (rx_axis_tvalid) begin
          wr_ptr_d = CNT_W'(1);
          if (rx_axis_tlast) begin
            drop_inc = 1'b1;
          end else if (start_full) begin
            state_d  = DROP;
            drop_inc = 1'b1;
          end else begin
            state_d = RECV;
            wr_en   = 1'b1;
            wr_off  = '0;
          end
        end
      end
      RECV: begin
        if (rx_axis_tvalid) begin
          wr_en    = 1'b1;
          wr_ptr_d = new_len;
          if (rx_axis_tlast) begin
            if (!filt_ok) begin
              state_d = IDLE;
            end else if (rx_axis_tuser || (new_len < CNT_MIN)) begin
              state_d  = IDLE;
              drop_inc = 1'b1;
            end else begin
              state_d = COMMIT;
              len_ld  = 1'b1;
            end
          end else if (!filt_ok) begin
            state_d = DROP;
          end else if (new_len == CNT_END) begin
            state_d  = DROP;
            drop_inc = 1'b1;
          end
        end
      end
      DROP: begin
        if (rx_axis_tvalid && rx_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      wr_ptr_q    <= '0;
      dest_q      <= '0;
      frame_len_q <= '0;
      nextbuf     <= '0;
      firstbuf    <= '0;
      drop_cnt    <= '0;
      eth_irq     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (wr_en)   dest_q      <= dest_now[39:0];
      if (len_ld)  frame_len_q <= 16'(new_len);
      if (state_q == COMMIT) nextbuf <= nextbuf + PTR_W'(1);
      if (firstbuf_we) firstbuf <= firstbuf_wdata;
      if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      eth_irq <= avail & irq_en;
    end
  end

  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      for (int i = 0; i < NBUF; i++) len_table[i] <= '0;
    end else if (state_q == COMMIT) begin
      len_table[nextbuf[IDX_W-1:0]] <= frame_len_q;
    end
  end

  always_ff @(posedge clk_int) begin
    if (wr_en)
      mem[{wr_slot, wr_off[OFF_W-1:LANE_W]}][{wr_off[LANE_W-1:0], 3'b000} +: 8] <= rx_axis_tdata;
  end

  always_ff @(posedge clk_int) begin
    if (rst_int)    rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_eth_rx_ring.sv
// Directed bench for eth_rx_ring: filtering, drop rules, ring fill/wrap, back-to-back frames
// and mid-frame reset, with expected values computed from the frame byte pattern.
module tb_eth_rx_ring;

  logic        clk_int = 1'b0;
  logic        rst_int = 1'b1;
  logic [7:0]  rx_axis_tdata = '0;
  logic        rx_axis_tvalid = 1'b0;
  logic        rx_axis_tlast = 1'b0;
  logic        rx_axis_tuser = 1'b0;
  logic [47:0] mac_address = 48'h0200_0000_0002;
  logic        promiscuous = 1'b0;
  logic        irq_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [10:0] rd_addr = '0;
  logic [63:0] rd_data;
  logic [2:0]  len_idx = '0;
  logic [15:0] len_data;
  logic        firstbuf_we = 1'b0;
  logic [3:0]  firstbuf_wdata = '0;
  logic [3:0]  firstbuf, nextbuf;
  logic        avail, full, eth_irq;
  logic [15:0] drop_cnt;

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OWN   = 48'h0200_0000_0002;
  localparam logic [47:0] OTHER = 48'h0200_0000_0001;
  localparam logic [47:0] MCAST = 48'h0100_5E01_0203;

  int checks = 0;
  int errors = 0;

  eth_rx_ring #(.NBUF(8), .BUF_BYTES(2048), .HOST_W(64), .MIN_LEN(14)) dut (
    .clk_int(clk_int), .rst_int(rst_int),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tvalid(rx_axis_tvalid),
    .rx_axis_tlast(rx_axis_tlast), .rx_axis_tuser(rx_axis_tuser),
    .mac_address(mac_address), .promiscuous(promiscuous), .irq_en(irq_en),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .len_idx(len_idx), .len_data(len_data),
    .firstbuf_we(firstbuf_we), .firstbuf_wdata(firstbuf_wdata),
    .firstbuf(firstbuf), .nextbuf(nextbuf), .avail(avail), .full(full),
    .drop_cnt(drop_cnt), .eth_irq(eth_irq)
  );

  always #5 clk_int = ~clk_int;

  function automatic logic [7:0] fbyte(input logic [47:0] dst, input logic [7:0] seed, input int i);
    if (i < 6) return dst[8*(5-i) +: 8];
    return seed + 8'(i);
  endfunction

  function automatic logic [63:0] exp_word(input logic [47:0] dst, input logic [7:0] seed, input int w);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = fbyte(dst, seed, w*8 + b);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_byte(input logic [7:0] d, input logic last, input logic user);
    rx_axis_tvalid = 1'b1;
    rx_axis_tdata  = d;
    rx_axis_tlast  = last;
    rx_axis_tuser  = user;
    @(posedge clk_int); #1;
  endtask

  task automatic idle(input int n);
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
    repeat (n) begin @(posedge clk_int); #1; end
  endtask

  task automatic send_frame(input logic [47:0] dst, input int len, input logic user, input logic [7:0] seed);
    for (int i = 0; i < len; i++)
      put_byte(fbyte(dst, seed, i), i == len-1, user && (i == len-1));
  endtask

  task automatic len_chk(input string tag, input logic [2:0] idx, input logic [15:0] exp);
    len_idx = idx;
    #1;
    chk(tag, len_data, exp);
  endtask

  task automatic rd_chk(input string tag, input int slot, input int w, input logic [47:0] dst,
                        input logic [7:0] seed);
    rd_en   = 1'b1;
    rd_addr = 11'(slot*256 + w);
    @(posedge clk_int); #1;
    rd_en = 1'b0;
    chk(tag, rd_data, exp_word(dst, seed, w));
  endtask

  task automatic write_firstbuf(input logic [3:0] v);
    firstbuf_we    = 1'b1;
    firstbuf_wdata = v;
    @(posedge clk_int); #1;
    firstbuf_we = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk_int);
    #1 rst_int = 1'b0;
    chk("rst_nextbuf", nextbuf, 0);
    chk("rst_firstbuf", firstbuf, 0);
    chk("rst_avail", avail, 0);
    chk("rst_full", full, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_irq", eth_irq, 0);
    chk("rst_rd_data", rd_data, 0);

    // T1 broadcast 64 bytes
    irq_en = 1'b1;
    send_frame(BCAST, 64, 1'b0, 8'h10);
    idle(2);
    chk("t1_nextbuf", nextbuf, 1);
    chk("t1_avail", avail, 1);
    chk("t1_irq", eth_irq, 1);
    chk("t1_drop", drop_cnt, 0);
    len_chk("t1_len", 3'd0, 16'd64);
    for (int w = 0; w < 8; w++) rd_chk("t1_rd", 0, w, BCAST, 8'h10);
    irq_en = 1'b0;
    idle(1);
    chk("irq_off", eth_irq, 0);
    irq_en = 1'b1;
    idle(1);
    chk("irq_on", eth_irq, 1);

    // T2 filter
    send_frame(OTHER, 20, 1'b0, 8'h20);
    idle(2);
    chk("t2_filt_nextbuf", nextbuf, 1);
    chk("t2_filt_drop", drop_cnt, 0);
    promiscuous = 1'b1;
    send_frame(OTHER, 20, 1'b0, 8'h21);
    idle(2);
    promiscuous = 1'b0;
    chk("t2_prom_nextbuf", nextbuf, 2);
    len_chk("t2_prom_len", 3'd1, 16'd20);
    rd_chk("t2_rd0", 1, 0, OTHER, 8'h21);
    rd_chk("t2_rd1", 1, 1, OTHER, 8'h21);
    send_frame(MCAST, 30, 1'b0, 8'h30);
    idle(2);
    chk("mcast_nextbuf", nextbuf, 3);
    len_chk("mcast_len", 3'd2, 16'd30);
    send_frame(OWN, 14, 1'b0, 8'h40);
    idle(2);
    chk("minlen_nextbuf", nextbuf, 4);
    len_chk("minlen_len", 3'd3, 16'd14);
    send_frame(BCAST, 13, 1'b0, 8'h41);
    idle(2);
    chk("runt_nextbuf", nextbuf, 4);
    chk("runt_drop", drop_cnt, 1);

    // T4 errored and oversize
    send_frame(BCAST, 40, 1'b1, 8'h50);
    idle(2);
    chk("tuser_nextbuf", nextbuf, 4);
    chk("tuser_drop", drop_cnt, 2);
    send_frame(BCAST, 2049, 1'b0, 8'h00);
    idle(2);
    chk("over_nextbuf", nextbuf, 4);
    chk("over_drop", drop_cnt, 3);
    send_frame(BCAST, 2048, 1'b0, 8'h60);
    idle(2);
    chk("max_nextbuf", nextbuf, 5);
    len_chk("max_len", 3'd4, 16'd2048);
    rd_chk("max_rd_first", 4, 0, BCAST, 8'h60);
    rd_chk("max_rd_last", 4, 255, BCAST, 8'h60);
    put_byte(8'hFF, 1'b1, 1'b0);
    idle(2);
    chk("single_drop", drop_cnt, 4);
    chk("single_nextbuf", nextbuf, 5);

    // T5 back-to-back
    send_frame(BCAST, 20, 1'b0, 8'h70);
    send_frame(BCAST, 25, 1'b0, 8'h80);
    idle(2);
    chk("b2b_nextbuf", nextbuf, 7);
    chk("b2b_drop", drop_cnt, 4);
    len_chk("b2b_len_a", 3'd5, 16'd20);
    len_chk("b2b_len_b", 3'd6, 16'd25);
    rd_chk("b2b_rd_a", 5, 0, BCAST, 8'h70);
    rd_chk("b2b_rd_b", 6, 0, BCAST, 8'h80);

    // T3 full ring
    send_frame(BCAST, 16, 1'b0, 8'h90);
    idle(2);
    chk("fill_nextbuf", nextbuf, 8);
    chk("fill_full", full, 1);
    send_frame(BCAST, 16, 1'b0, 8'h91);
    idle(2);
    chk("fulldrop_nextbuf", nextbuf, 8);
    chk("fulldrop_drop", drop_cnt, 5);
    write_firstbuf(4'd1);
    chk("free_firstbuf", firstbuf, 1);
    chk("free_full", full, 0);
    send_frame(BCAST, 50, 1'b0, 8'hA0);
    idle(2);
    chk("wrap_nextbuf", nextbuf, 9);
    chk("wrap_full", full, 1);
    len_chk("wrap_len", 3'd0, 16'd50);
    rd_chk("wrap_rd", 0, 1, BCAST, 8'hA0);
    write_firstbuf(4'd9);
    chk("drain_avail", avail, 0);
    chk("drain_irq_hold", eth_irq, 1);
    idle(1);
    chk("drain_irq_fall", eth_irq, 0);

    // T6 reset mid-frame
    for (int i = 0; i < 10; i++) put_byte(fbyte(BCAST, 8'h00, i), 1'b0, 1'b0);
    rx_axis_tvalid = 1'b0;
    rst_int = 1'b1;
    @(posedge clk_int); #1;
    rst_int = 1'b0;
    chk("t6_nextbuf", nextbuf, 0);
    chk("t6_firstbuf", firstbuf, 0);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_irq", eth_irq, 0);
    chk("t6_avail", avail, 0);
    send_frame(OWN, 16, 1'b0, 8'hB0);
    idle(2);
    chk("t6_after_nextbuf", nextbuf, 1);
    chk("t6_after_drop", drop_cnt, 0);
    len_chk("t6_after_len", 3'd0, 16'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
